regdump_tx: RTL and testbench
=============================

REGDUMP_TX -- requirements
Module: regdump_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter LOG2_NUM_REGS, default 4: log2 of the register count (NUM_REGS = 2**LOG2_NUM_REGS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one register dump; sampled each cycle.
REQ-006 SHALL have port debug_regs  input  NUM_REGS x WIDTH unpacked array  live register contents from the register file debug port.
REQ-007 SHALL have port tx_data  output  8  byte being offered downstream (UART TX side).
REQ-008 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-009 SHALL have port tx_ready  input  1  downstream accepts the byte; a transfer occurs on any cycle with tx_valid && tx_ready.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until the frame completes.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final byte transfers.

Function
REQ-012 SHALL emit one frame per accepted start: header 8'hA5, then NUM_REGS*WIDTH/8 data bytes, then one checksum byte (66 bytes at the default parameters).
REQ-013 SHALL order data bytes by register index 0 to NUM_REGS-1, with each register sent most-significant byte first.
REQ-014 SHALL compute the checksum as the XOR of all data bytes; the header is excluded.
REQ-015 SHALL accept start only in IDLE and SHALL ignore start in every other state, without queuing it.
REQ-016 SHALL, on the cycle start is accepted, capture all of debug_regs into an internal snapshot; later changes to debug_regs SHALL NOT affect the frame.
REQ-017 SHALL implement the states IDLE, HEADER, DATA, CSUM and DONE:
- IDLE -> HEADER on start.
- HEADER -> DATA on transfer.
- DATA -> CSUM on transfer of the last data byte.
- CSUM -> DONE on transfer.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL assert tx_valid in HEADER, DATA and CSUM, and only there; when start is accepted in cycle N, tx_valid with 8'hA5 SHALL appear in cycle N+1.
REQ-019 SHALL hold tx_data and tx_valid stable while tx_valid && !tx_ready.
REQ-020 SHALL sustain one byte per cycle while tx_ready is held high; there are no bubbles between bytes.
REQ-021 SHALL use a register-index counter (LOG2_NUM_REGS bits) and a byte-index counter (log2(WIDTH/8) bits) that advance only on transfer and reset to 0 on entry to HEADER; the byte counter wraps into a register-counter increment.
REQ-022 SHALL assert busy in HEADER, DATA and CSUM, and assert done only in DONE.
REQ-023 SHALL drive tx_data to 8'h00 whenever tx_valid is low.

Reset
REQ-024 SHALL, while rst is high, force state = IDLE, tx_valid = 0, tx_data = 8'h00, busy = 0, done = 0, counters = 0, checksum = 0; the snapshot value is don't-care.
REQ-025 SHALL abandon a frame when reset occurs mid-frame, without completing or resuming it; the next start after reset SHALL produce a complete frame beginning with the header.

Structure
REQ-026 SHALL take the state enum type and the constant HEADER_BYTE = 8'hA5 from a shared package, regdump_pkg.
REQ-027 SHALL be a single module with no sub-module; the snapshot array, byte multiplexer, counters and FSM are implemented inline.

Verification
REQ-028 SHALL cover all-zero registers: all debug_regs = 0, start, tx_ready = 1 -> A5, 64 x 00, checksum 00, then a done pulse at byte count 66+1.
REQ-029 SHALL cover byte order and checksum: debug_regs[1] = 32'h12345678, others 0 -> frame bytes 5..8 = 12 34 56 78 (header = byte 0), checksum 08.
REQ-030 SHALL cover backpressure: tx_ready dropped for 5 cycles at data byte 10 -> tx_data and tx_valid held constant; the frame completes intact and the total cycle count increases by 5.
REQ-031 SHALL cover snapshot coherency: debug_regs[0] changed from 32'hAAAAAAAA to 32'h55555555 one cycle after start -> AA AA AA AA is transmitted.
REQ-032 SHALL cover start while busy: start pulsed at data byte 20 -> ignored, exactly one frame and one done pulse are produced.
REQ-033 SHALL cover reset mid-frame: rst asserted at data byte 30 -> tx_valid = 0 and busy = 0 immediately; a new start then yields a full 66-byte frame beginning with A5.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared types and constants for the register dump transmitter.
package regdump_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Sync byte that opens every frame
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

endpackage : regdump_pkg

// File: rtl/regdump_tx.sv
// Register dump transmitter: on start, snapshots the register file and
// streams it out as a byte frame (header, MSB-first register bytes, XOR
// checksum) over a valid/ready byte interface.
module regdump_tx
  import regdump_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int LOG2_NUM_REGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] debug_regs [2**LOG2_NUM_REGS],
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NUM_REGS = 2**LOG2_NUM_REGS;
  localparam int unsigned BYTES    = WIDTH / 8;
  localparam int unsigned BW       = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [LOG2_NUM_REGS-1:0] LAST_REG  = '1;
  localparam logic [BW-1:0]            LAST_BYTE = BW'(BYTES - 1);

  state_e                   state_q, state_d;
  logic [LOG2_NUM_REGS-1:0] reg_idx_q, reg_idx_d;
  logic [BW-1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]               csum_q, csum_d;
  logic [WIDTH-1:0]         snap_q [NUM_REGS];
  logic [WIDTH-1:0]         snap_d [NUM_REGS];

  logic                     accept;
  logic                     xfer;
  logic                     last_data;
  logic [WIDTH-1:0]         cur_word;
  logic [BW-1:0]            byte_sel;
  logic [7:0]               data_byte;

  assign accept    = (state_q == ST_IDLE) && start;
  assign xfer      = tx_valid && tx_ready;
  assign last_data = (reg_idx_q == LAST_REG) && (byte_idx_q == LAST_BYTE);

  // Select the current data byte from the snapshot, most-significant first
  always_comb begin
    cur_word  = snap_q[reg_idx_q];
    byte_sel  = LAST_BYTE - byte_idx_q;
    data_byte = cur_word[{byte_sel, 3'b000} +: 8];
  end

  // Output decode: everything is a function of state, so it is stable under backpressure
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        busy     = 1'b1;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        busy     = 1'b1;
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        busy     = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, counter and checksum logic
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HEADER;
          reg_idx_d  = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end
      ST_HEADER: begin
        if (xfer) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ data_byte;
          // Byte counter wraps into a register step; on the last byte both return to 0
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            reg_idx_d  = reg_idx_q + LOG2_NUM_REGS'(1);
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
          if (last_data) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (xfer) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Snapshot capture on start acceptance
  always_comb begin
    snap_d = snap_q;
    if (accept) snap_d = debug_regs;
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
    end
  end

  // Snapshot storage; contents are irrelevant until the next accepted start
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

endmodule : regdump_tx

// File: tb/tb_regdump_tx.sv
// Self-checking bench for regdump_tx: frames are predicted from the
// register values at start time and compared byte by byte.
module tb_regdump_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] debug_regs [16];
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  regdump_tx #(.WIDTH(32), .LOG2_NUM_REGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .debug_regs (debug_regs),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: header, every register MSB first, XOR of the data bytes
  task automatic build_expected();
    logic [7:0] cs;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((debug_regs[r] >> (24 - 8 * k)) & 32'hFF);
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 five-cycle drop at data byte 10
  task automatic do_frame(input int ready_mode, input int busy_start_at,
                          input bit change_reg0, input int reset_at,
                          output bit aborted);
    int         idx;
    int         cyc;
    int         stalls;
    int         dropped;
    bit         stalled;
    bit         fin;
    bit         r;
    logic [7:0] held;
    aborted = 1'b0;
    got_q.delete();
    @(negedge clk);
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (change_reg0) debug_regs[0] = 32'h55555555;
    idx = 0; cyc = 0; stalls = 0; dropped = 0; stalled = 1'b0; fin = 1'b0; held = 8'h00;
    while (!fin && cyc < 400) begin
      cyc++;
      if (idx == exp_q.size()) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(tx_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("frame_cycles", cyc, 67 + stalls);
        fin = 1'b1;
      end else begin
        check("valid", 32'(tx_valid), 32'd1);
        check("busy", 32'(busy), 32'd1);
        check("no_early_done", 32'(done), 32'd0);
        if (stalled) check("hold_data", 32'(tx_data), 32'(held));
        if (reset_at >= 0 && idx == reset_at + 1) begin
          start = 1'b0;
          rst = 1'b1;
          #1;
          check("rst_valid", 32'(tx_valid), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_data", 32'(tx_data), 32'd0);
          check("rst_done", 32'(done), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          aborted = 1'b1;
          fin = 1'b1;
        end else begin
          start = (busy_start_at >= 0 && idx == busy_start_at + 1);
          case (ready_mode)
            1:       r = ($urandom_range(0, 9) < 7);
            2:       r = !(idx == 11 && dropped < 5);
            default: r = 1'b1;
          endcase
          if (!r && ready_mode == 2) dropped++;
          tx_ready = r;
          if (r) begin
            check("frame_byte", 32'(tx_data), 32'(exp_q[idx]));
            got_q.push_back(tx_data);
            idx++;
            stalled = 1'b0;
          end else begin
            stalls++;
            stalled = 1'b1;
            held = tx_data;
          end
          @(negedge clk);
        end
      end
    end
    start = 1'b0;
    tx_ready = 1'b0;
    if (!fin) check("timeout", 32'd0, 32'd1);
    if (!aborted) begin
      repeat (3) begin
        @(negedge clk);
        check("idle_valid", 32'(tx_valid), 32'd0);
        check("idle_data", 32'(tx_data), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    bit ab;
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) debug_regs[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero registers
    do_frame(0, -1, 1'b0, -1, ab);
    check("zero_len", got_q.size(), 66);
    if (got_q.size() == 66) check("zero_csum", 32'(got_q[65]), 32'h00);

    // Byte order and checksum
    debug_regs[1] = 32'h12345678;
    do_frame(0, -1, 1'b0, -1, ab);
    check("order_len", got_q.size(), 66);
    if (got_q.size() == 66) begin
      check("order_b5", 32'(got_q[5]), 32'h12);
      check("order_b6", 32'(got_q[6]), 32'h34);
      check("order_b7", 32'(got_q[7]), 32'h56);
      check("order_b8", 32'(got_q[8]), 32'h78);
      check("order_csum", 32'(got_q[65]), 32'h08);
    end

    // Backpressure at data byte 10
    for (int i = 0; i < 16; i++) debug_regs[i] = $urandom;
    do_frame(2, -1, 1'b0, -1, ab);

    // Snapshot coherency
    for (int i = 0; i < 16; i++) debug_regs[i] = $urandom;
    debug_regs[0] = 32'hAAAAAAAA;
    do_frame(0, -1, 1'b1, -1, ab);
    if (got_q.size() == 66) begin
      for (int k = 1; k <= 4; k++) check("snap_reg0", 32'(got_q[k]), 32'hAA);
    end

    // Start while busy
    for (int i = 0; i < 16; i++) debug_regs[i] = $urandom;
    do_frame(1, 20, 1'b0, -1, ab);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 16; i++) debug_regs[i] = $urandom;
    do_frame(0, -1, 1'b0, 30, ab);
    check("rst_aborted", 32'(ab), 32'd1);
    @(negedge clk);
    check("post_rst_idle", 32'(tx_valid), 32'd0);
    do_frame(0, -1, 1'b0, -1, ab);
    check("post_rst_len", got_q.size(), 66);
    if (got_q.size() == 66) check("post_rst_hdr", 32'(got_q[0]), 32'hA5);

    // Random registers under random backpressure
    repeat (4) begin
      for (int i = 0; i < 16; i++) debug_regs[i] = $urandom;
      do_frame(1, -1, 1'b0, -1, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regdump_tx
